instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
// - Producer end of the instr_i interface of the control unit: fetches RV32I instruction words and presents one at a time.
// - Owns the PC and talks to instruction memory (variable latency, one outstanding request).
// - Consumes br_sel and the ALU target to redirect the PC.
// - Sits between the imem port and ctrl_unit / regfile / immediate generator.
// PARAMETERS
// - RESET_PC  32'h0000_0000  PC loaded on reset; first fetch address.
// - NOP_INSTR 32'h0000_0013  value on instr_o while instr_valid_o=0 (addi x0,x0,0).
// PORTS
// - clk_i           in   1   single clock, rising edge
// - rst_i           in   1   reset, asynchronous, active-high
// - imem_req_o      out  1   fetch request to instruction memory
// - imem_addr_o     out  32  fetch address (= pc_q, word aligned)
// - imem_ready_i    in   1   imem accepts request this cycle (req & ready = accepted)
// - imem_rvalid_i   in   1   response valid; earliest one cycle after acceptance
// - imem_rdata_i    in   32  response instruction word
// - instr_o         out  32  instruction to ctrl_unit / decode
// - instr_valid_o   out  1   instr_o / pc_o valid
// - instr_ack_i     in   1   core retires the presented instruction this cycle
// - pc_o            out  32  PC of instr_o
// - pc_four_o       out  32  pc_o + 4 (JAL/JALR writeback)
// - br_sel_i        in   1   from ctrl_unit; sampled only when instr_ack_i=1
// - br_target_i     in   32  ALU result = branch/jump target
// - flush_i         in   1   external redirect (trap/debug); overrides everything
// - flush_pc_i      in   32  redirect target for flush_i
// - misalign_o      out  1   sticky: a redirect target had bit1 set
// BEHAVIOUR
// - FSM states: S_REQ, S_WAIT, S_HOLD.
// - Reset (async): state=S_REQ, pc_q=RESET_PC, drop_q=0, misalign_o=0, instr_valid_o=0, instr_o=NOP_INSTR.
// - imem_req_o=1 only in S_REQ.
// - S_REQ:
//   - imem_req_o=1, imem_addr_o=pc_q.
//   - req & ready -> S_WAIT; otherwise hold request and address stable.
// - S_WAIT:
//   - on imem_rvalid_i & !drop_q: capture rdata into instr_q -> S_HOLD.
//   - on imem_rvalid_i & drop_q: discard, clear drop_q -> S_REQ.
// - S_HOLD:
//   - instr_valid_o=1, instr_o=instr_q, pc_o=pc_q.
//   - instr_ack_i: pc_q <= br_sel_i ? {br_target_i[31:1],1'b0} : pc_q+4 -> S_REQ.
//   - Word fetch uses {pc_q[31:2],2'b00}.
// - instr_valid_o=0 outside S_HOLD; instr_o=NOP_INSTR, so ctrl_unit sees a benign opcode.
// - flush_i, highest priority, any state:
//   - pc_q <= flush_pc_i (bit0 cleared); next state S_REQ; instr_valid_o drops next cycle.
//   - If a request is outstanding (S_WAIT, or S_REQ with ready=1 this cycle): drop_q <= 1.
//   - Flush in S_HOLD discards instr_q; ack in the same cycle is ignored.
// - misalign_o set when a loaded target (branch or flush) has bit1=1; cleared only by rst_i.
// - PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
// - Latency: ack at cycle N -> request at N+1; with ready=1 and rvalid at N+2 -> instr_valid_o at N+3.
// - instr_ack_i outside S_HOLD is ignored. imem_rvalid_i outside S_WAIT is ignored (assertion flags it).
// - Reset mid-request: state forced to S_REQ; imem must tolerate request abandonment.
// STRUCTURE
// - Shared package rv32_pkg:
//   - fetch_state_e {S_REQ,S_WAIT,S_HOLD}
//   - OPC_JAL/OPC_JALR/OPC_BRANCH constants
//   - NOP_INSTR default
// - Single module; no sub-module (PC adder inline).
// TESTING
// - Reset release, ready=1, rvalid 1 cycle later with 32'h00500093 -> req addr 0; instr_valid_o at cycle 3; pc_o=0; pc_four_o=4.
// - Three acks with br_sel_i=0 -> fetch addresses 0,4,8; rvalid delayed 3 cycles -> valid waits, no duplicate requests.
// - Ack with br_sel_i=1, br_target_i=32'h0000_0101 -> next addr 32'h100, misalign_o=0.
// - Target 32'h0000_0102 -> misalign_o=1 and stays 1.
// - flush_i in S_WAIT with flush_pc_i=32'h200 -> stale rvalid data never appears on instr_o; next request addr 32'h200.
// - pc_q=32'hFFFF_FFFC, ack with no branch -> next addr 0.
// - rst_i asserted in S_HOLD -> outputs at reset values asynchronously; first request after release at RESET_PC.
// - imem_ready_i=0 for 5 cycles -> imem_addr_o held stable and imem_req_o stays 1.

Source files
------------

// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared RV32I definitions for the fetch/decode slice of the core.
//   fetch_state_e      : states of the instruction fetch FSM
//   OPC_JAL/JALR/BRANCH: major opcodes of control-transfer instructions
//   DEFAULT_NOP_INSTR  : addi x0,x0,0, shown to decode when nothing is valid
// ---------------------------------------------------------------------------
package rv32_pkg;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD
   } fetch_state_e;

   localparam logic [6:0]  OPC_JAL           = 7'b110_1111;
   localparam logic [6:0]  OPC_JALR          = 7'b110_0111;
   localparam logic [6:0]  OPC_BRANCH        = 7'b110_0011;

   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Owns the PC, fetches one RV32I word at a time from a variable-latency
// instruction memory (one outstanding request) and presents it to decode
// until the core acknowledges it. Branch/jump targets and external flushes
// redirect the PC.
//
// Ports
//   clk_i, rst_i      : clock (rising edge), asynchronous active-high reset
//   imem_req_o        : fetch request, imem_addr_o = word-aligned PC
//   imem_ready_i      : request accepted when req & ready
//   imem_rvalid_i     : response strobe, imem_rdata_i = instruction word
//   instr_o           : instruction to decode (NOP while not valid)
//   instr_valid_o     : instr_o / pc_o valid
//   instr_ack_i       : core retires the presented instruction
//   pc_o, pc_four_o   : PC of instr_o and PC+4
//   br_sel_i          : take br_target_i on ack
//   br_target_i       : branch/jump target from the ALU
//   flush_i           : external redirect to flush_pc_i, highest priority
//   flush_pc_i        : redirect target
//   misalign_o        : sticky, a loaded target had bit1 set
// ---------------------------------------------------------------------------
module instr_fetch_unit
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   input  logic        instr_ack_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_four_o,
   input  logic        br_sel_i,
   input  logic [31:0] br_target_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   output logic        misalign_o
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q;
   logic         drop_q, drop_d;
   logic         misalign_q, misalign_d;
   logic         accepted;
   logic         capture;

   // Bit 0 of every target is forced to zero, so it is never consumed.
   logic         unused_bits;
   assign unused_bits = br_target_i[0] ^ flush_pc_i[0];

   // While a flushed request is still in flight (drop_q in S_REQ) no new
   // request is issued, which keeps imem at one outstanding transaction.
   // The stale response is swallowed wherever it lands.
   assign imem_req_o    = (state_q == S_REQ) && !drop_q;
   assign imem_addr_o   = {pc_q[31:2], 2'b00};
   assign accepted      = imem_req_o && imem_ready_i;

   assign instr_valid_o = (state_q == S_HOLD);
   assign instr_o       = instr_valid_o ? instr_q : NOP_INSTR;
   assign pc_o          = pc_q;
   assign pc_four_o     = pc_q + 32'd4;
   assign misalign_o    = misalign_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drop_d     = drop_q;
      misalign_d = misalign_q;
      capture    = 1'b0;

      unique case (state_q)
         S_REQ: begin
            if (drop_q && imem_rvalid_i) drop_d = 1'b0;
            if (accepted) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid_i) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  capture = 1'b1;
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (instr_ack_i) begin
               pc_d    = br_sel_i ? {br_target_i[31:1], 1'b0} : pc_q + 32'd4;
               state_d = S_REQ;
               if (br_sel_i && br_target_i[1]) misalign_d = 1'b1;
            end
         end
         default: state_d = S_REQ;
      endcase

      // Flush overrides everything above, including a same-cycle ack.
      // drop_d marks whether a response is still owed by imem after this
      // cycle: a pending stale one, the one being waited on, or the one
      // being accepted right now.
      if (flush_i) begin
         pc_d       = {flush_pc_i[31:1], 1'b0};
         state_d    = S_REQ;
         capture    = 1'b0;
         drop_d     = (drop_q && !imem_rvalid_i)
                    || ((state_q == S_WAIT) && !imem_rvalid_i)
                    || accepted;
         misalign_d = misalign_q | flush_pc_i[1];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         drop_q     <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drop_q     <= drop_d;
         misalign_q <= misalign_d;
      end
   end

   // Instruction word is only observed in S_HOLD, so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (capture) instr_q <= imem_rdata_i;
   end

`ifndef SYNTHESIS
   // A response is only legal while one is owed.
   rvalid_expected_a : assert property (@(posedge clk_i) disable iff (rst_i)
      imem_rvalid_i |-> ((state_q == S_WAIT) || drop_q));
`endif

endmodule
